// File: rtl/store_write_buffer_if.sv
// store_write_buffer_if: CPU-side and memory-side signals of the store write buffer
interface store_write_buffer_if #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic              cpu_memRead;
   logic              cpu_memWrite;
   logic [ADDR_W-1:0] cpu_address;
   logic [DATA_W-1:0] cpu_writeData;
   logic [DATA_W-1:0] cpu_readData;
   logic              cpu_stall;
   logic              mem_memRead;
   logic              mem_memWrite;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_writeData;
   logic [DATA_W-1:0] mem_readData;
   logic [CW-1:0]     wb_count;
   logic              wb_empty;
   modport master (
      output cpu_memRead, cpu_memWrite, cpu_address, cpu_writeData, mem_readData,
      input  cpu_readData, cpu_stall, mem_memRead, mem_memWrite, mem_address, mem_writeData,
             wb_count, wb_empty
   );
   modport slave (
      input  cpu_memRead, cpu_memWrite, cpu_address, cpu_writeData, mem_readData,
      output cpu_readData, cpu_stall, mem_memRead, mem_memWrite, mem_address, mem_writeData,
             wb_count, wb_empty
   );
endinterface

// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-store FIFO in front of data_memory with load forwarding.
// STORE_FWD_EN selects forwarding; without it a hitting load stalls until the entry drains.
module store_write_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic clk,
   input logic rst,
   store_write_buffer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PW-1:0]     head, tail;
   logic [CW-1:0]     count;
   logic              full, hit, hit_stall, load, store, push, pop;
   logic [DATA_W-1:0] hit_data;
   // scan oldest to youngest so the youngest matching entry is the one left standing
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (CW'(k) < count && addr_q[head + PW'(k)] == bus.cpu_address) begin
            hit      = 1'b1;
            hit_data = data_q[head + PW'(k)];
         end
      end
   end
`ifdef STORE_FWD_EN
   assign hit_stall = 1'b0;
   assign bus.cpu_readData = bus.cpu_memRead ? (hit ? hit_data : bus.mem_readData) : '0;
`else
   assign hit_stall = !rst && bus.cpu_memRead && hit;
   assign bus.cpu_readData = load ? bus.mem_readData : '0;
`endif
   assign full  = count == CW'(DEPTH);
   assign load  = bus.cpu_memRead && !hit_stall;
   assign store = bus.cpu_memWrite && !bus.cpu_memRead;
   assign pop   = !rst && !load && count != '0;
   assign push  = !rst && store && !full;
   assign bus.cpu_stall     = !rst && ((store && full) || hit_stall);
   assign bus.mem_memRead   = load;
   assign bus.mem_memWrite  = pop;
   assign bus.mem_address   = load ? bus.cpu_address : pop ? addr_q[head] : '0;
   assign bus.mem_writeData = pop ? data_q[head] : '0;
   assign bus.wb_count      = rst ? '0 : count;
   assign bus.wb_empty      = rst || count == '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            addr_q[tail] <= bus.cpu_address;
            data_q[tail] <= bus.cpu_writeData;
            tail         <= tail + 1'b1;
         end
         if (pop) head <= head + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed scenarios plus random traffic against a queue-based model
module tb_store_write_buffer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   typedef struct {logic [31:0] a; logic [31:0] d;} ent_t;
   ent_t q[$];
   logic [31:0] ref_mem [8];
   logic [31:0] mem [8];
   store_write_buffer_if #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) bus ();
   store_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic bit in_range(input logic [31:0] a);
      return a >= 32'h3E8 && a < 32'h408;
   endfunction
   function automatic int widx(input logic [31:0] a);
      return int'((a - 32'h3E8) >> 2);
   endfunction
   always_comb bus.mem_readData = in_range(bus.mem_address) ? mem[widx(bus.mem_address)] : 32'h0;
   always @(posedge clk) if (bus.mem_memWrite && in_range(bus.mem_address)) mem[widx(bus.mem_address)] <= bus.mem_writeData;
   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return in_range(a) ? ref_mem[widx(a)] : 32'h0;
   endfunction
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step(input logic rs, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      logic hit, ld, hs, st, dr, full;
      logic [31:0] hd, er;
      @(negedge clk);
      rst = rs;
      bus.cpu_memRead = r;
      bus.cpu_memWrite = w;
      bus.cpu_address = a;
      bus.cpu_writeData = d;
      #1;
      hit = 1'b0;
      hd = 32'h0;
      foreach (q[i]) if (q[i].a == a) begin hit = 1'b1; hd = q[i].d; end
      full = q.size() == 4;
      if (rs) begin
         ld = 1'b0; st = 1'b0; dr = 1'b0; er = 32'h0;
      end else begin
`ifdef STORE_FWD_EN
         hs = 1'b0;
         ld = r;
         er = r ? (hit ? hd : ref_rd(a)) : 32'h0;
`else
         hs = r && hit;
         ld = r && !hit;
         er = ld ? ref_rd(a) : 32'h0;
`endif
         st = (w && !r && full) || hs;
         dr = !ld && q.size() != 0;
      end
      check("stall", bus.cpu_stall, st);
      check("rdata", bus.cpu_readData, er);
      check("mem_rd", bus.mem_memRead, ld);
      check("mem_wr", bus.mem_memWrite, dr);
      check("mem_addr", bus.mem_address, ld ? a : dr ? q[0].a : 32'h0);
      check("mem_wdata", bus.mem_writeData, dr ? q[0].d : 32'h0);
      check("count", bus.wb_count, rs ? 0 : q.size());
      check("empty", bus.wb_empty, rs || q.size() == 0);
      if (rs) q.delete();
      else begin
         if (dr) begin
            if (in_range(q[0].a)) ref_mem[widx(q[0].a)] = q[0].d;
            void'(q.pop_front());
         end
         if (w && !r && !full) q.push_back('{a, d});
      end
   endtask
   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask
   initial begin
      logic [31:0] ra;
      int load_pct;
      int op;
      for (int i = 0; i < 8; i++) begin mem[i] = 32'd10; ref_mem[i] = 32'd10; end
      bus.cpu_memRead = 1'b0;
      bus.cpu_memWrite = 1'b0;
      bus.cpu_address = 32'h0;
      bus.cpu_writeData = 32'h0;
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      idle();
      check("t0_empty", bus.wb_empty, 1'b1);
      step(1'b0, 1'b0, 1'b1, 32'h3E8, 32'hDEADBEEF);
      idle();
      check("t1_count", bus.wb_count, 1);
      check("t1_wr", bus.mem_memWrite, 1'b1);
      check("t1_addr", bus.mem_address, 32'h3E8);
      check("t1_data", bus.mem_writeData, 32'hDEADBEEF);
      idle();
      check("t1_empty", bus.wb_empty, 1'b1);
      step(1'b0, 1'b0, 1'b1, 32'h3EC, 32'h11111111);
      step(1'b0, 1'b0, 1'b1, 32'h3EC, 32'h22222222);
      step(1'b0, 1'b1, 1'b0, 32'h3EC, 32'h0);
`ifdef STORE_FWD_EN
      check("t3_fwd", bus.cpu_readData, 32'h22222222);
`else
      check("t3_stall", bus.cpu_stall, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h3EC, 32'h0);
      check("t3_mem", bus.cpu_readData, 32'h22222222);
`endif
      idle();
      idle();
      step(1'b0, 1'b0, 1'b1, 32'h3E8, 32'h7);
      step(1'b0, 1'b1, 1'b0, 32'h3F0, 32'h0);
      check("t4_addr", bus.mem_address, 32'h3F0);
      check("t4_rdata", bus.cpu_readData, 32'd10);
      check("t4_wr", bus.mem_memWrite, 1'b0);
      check("t4_count", bus.wb_count, 1);
      idle();
      step(1'b0, 1'b0, 1'b1, 32'h3FC, 32'h99);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      idle();
      check("t5_wr", bus.mem_memWrite, 1'b0);
      check("t5_count", bus.wb_count, 0);
      step(1'b0, 1'b1, 1'b0, 32'h3FC, 32'h0);
      check("t5_rdata", bus.cpu_readData, 32'd10);
`ifndef STORE_FWD_EN
      step(1'b0, 1'b0, 1'b1, 32'h3EC, 32'h5);
      step(1'b0, 1'b1, 1'b0, 32'h3EC, 32'h0);
      check("t6_stall", bus.cpu_stall, 1'b1);
      check("t6_rd", bus.mem_memRead, 1'b0);
      step(1'b0, 1'b1, 1'b0, 32'h3EC, 32'h0);
      check("t6_rdata", bus.cpu_readData, 32'h5);
      check("t6_nostall", bus.cpu_stall, 1'b0);
`endif
      for (int blk = 0; blk < 10; blk++) begin
         load_pct = 20 + 15 * (blk % 5);
         for (int c = 0; c < 50; c++) begin
            ra = 32'h3E8 + 32'($urandom_range(0, 7)) * 4;
            op = int'($urandom_range(0, 99));
            if ($urandom_range(0, 63) == 0) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            else if (op < load_pct) step(1'b0, 1'b1, 1'b0, ra, 32'h0);
            else if (op < 90) step(1'b0, 1'b0, 1'b1, ra, $urandom);
            else if (op < 95) step(1'b0, 1'b1, 1'b1, ra, $urandom);
            else idle();
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
